// File: rtl/stack_unit.sv
// LIFO stack with registered top-of-stack, replace (push+pop), sticky
// overflow/underflow flags and a high-water mark of occupancy.
module stack_unit #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   input  logic              clr_err,
   output logic [DATA_W-1:0] top,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              ovf,
   output logic              unf,
   output logic [CNT_W-1:0]  hwm
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count, r_hwm;
   logic [DATA_W-1:0] r_top, r_pop_data;
   logic              r_pop_valid, r_ovf, r_unf;

   logic              w_full, w_empty;
   logic              w_wr, w_pop, w_repl, w_ovf_ev, w_unf_ev;
   logic [AW-1:0]     w_top_idx, w_nxt_idx, w_wr_idx;
   logic [CNT_W-1:0]  w_cnt_nxt;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);

   // push+pop on an empty stack degrades to a plain push (and flags unf)
   assign w_wr     = (push & ~pop & ~w_full) | (push & pop & w_empty);
   assign w_pop    = pop & ~push & ~w_empty;
   assign w_repl   = push & pop & ~w_empty;
   assign w_ovf_ev = push & ~pop & w_full;
   assign w_unf_ev = pop & w_empty;

   assign w_top_idx = AW'(r_count - CNT_W'(1));
   assign w_nxt_idx = AW'(r_count - CNT_W'(2));
   assign w_wr_idx  = w_repl ? w_top_idx : AW'(r_count);

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_wr)       w_cnt_nxt = r_count + CNT_W'(1);
      else if (w_pop) w_cnt_nxt = r_count - CNT_W'(1);
   end

   // storage is not reset; entries above count are never observed
   always_ff @(posedge clk) begin
      if (w_wr | w_repl) r_mem[w_wr_idx] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_hwm       <= '0;
         r_top       <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         r_count     <= w_cnt_nxt;
         r_pop_valid <= w_pop | w_repl;
         r_ovf       <= w_ovf_ev | (r_ovf & ~clr_err);
         r_unf       <= w_unf_ev | (r_unf & ~clr_err);
         if (w_cnt_nxt > r_hwm) r_hwm <= w_cnt_nxt;
         if (w_pop | w_repl) r_pop_data <= r_mem[w_top_idx];
         if (w_wr | w_repl)
            r_top <= din;
         else if (w_pop)
            r_top <= (r_count == CNT_W'(1)) ? '0 : r_mem[w_nxt_idx];
      end
   end

   assign top       = r_top;
   assign pop_data  = r_pop_data;
   assign pop_valid = r_pop_valid;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign ovf       = r_ovf;
   assign unf       = r_unf;
   assign hwm       = r_hwm;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed table on a DEPTH=4 instance, async-reset
// sequence, and a random stream on a DEPTH=7 instance against a queue model.
module tb_stack_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // instance A: DATA_W=8, DEPTH=4
   logic       a_rst_n, a_push, a_pop, a_clr;
   logic [7:0] a_din, a_top, a_pd;
   logic       a_pv, a_full, a_empty, a_ovf, a_unf;
   logic [2:0] a_cnt, a_hwm;

   stack_unit #(.DATA_W(8), .DEPTH(4)) u_a (
      .clk(clk), .rst_n(a_rst_n), .push(a_push), .pop(a_pop), .din(a_din),
      .clr_err(a_clr), .top(a_top), .pop_data(a_pd), .pop_valid(a_pv),
      .count(a_cnt), .full(a_full), .empty(a_empty), .ovf(a_ovf),
      .unf(a_unf), .hwm(a_hwm));

   // instance B: DATA_W=8, DEPTH=7
   logic       b_rst_n, b_push, b_pop, b_clr;
   logic [7:0] b_din, b_top, b_pd;
   logic       b_pv, b_full, b_empty, b_ovf, b_unf;
   logic [2:0] b_cnt, b_hwm;

   stack_unit #(.DATA_W(8), .DEPTH(7)) u_b (
      .clk(clk), .rst_n(b_rst_n), .push(b_push), .pop(b_pop), .din(b_din),
      .clr_err(b_clr), .top(b_top), .pop_data(b_pd), .pop_valid(b_pv),
      .count(b_cnt), .full(b_full), .empty(b_empty), .ovf(b_ovf),
      .unf(b_unf), .hwm(b_hwm));

   typedef struct {
      logic       p, o, c;
      logic [7:0] d;
      int         cnt, top, pv, pd, ovf, unf, hwm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic p, logic o, logic [7:0] d, logic c,
                               int cnt, int tp, int pv, int pd, int ov,
                               int un, int hw);
      vec_t v;
      v.p = p; v.o = o; v.d = d; v.c = c;
      v.cnt = cnt; v.top = tp; v.pv = pv; v.pd = pd;
      v.ovf = ov; v.unf = un; v.hwm = hw;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_a(input string tag, input int cnt, input int tp, input int pv,
                          input int pd, input int ov, input int un, input int hw);
      chk({tag, " count"}, 32'(a_cnt), cnt);
      chk({tag, " top"},   32'(a_top), tp);
      chk({tag, " pv"},    32'(a_pv),  pv);
      chk({tag, " pd"},    32'(a_pd),  pd);
      chk({tag, " ovf"},   32'(a_ovf), ov);
      chk({tag, " unf"},   32'(a_unf), un);
      chk({tag, " hwm"},   32'(a_hwm), hw);
      chk({tag, " full"},  32'(a_full),  32'(cnt == 4));
      chk({tag, " empty"}, 32'(a_empty), 32'(cnt == 0));
   endtask

   task automatic step_a(input logic p, input logic o, input logic [7:0] d, input logic c);
      @(negedge clk);
      a_push = p; a_pop = o; a_din = d; a_clr = c;
      @(posedge clk);
      #1;
   endtask

   // reference model for instance B
   logic [7:0] q[$];
   logic [7:0] m_pd;
   logic       m_pv, m_ovf, m_unf;
   int         m_hwm;

   task automatic model_step(input logic p, input logic o, input logic [7:0] d, input logic c);
      if (c) begin m_ovf = 0; m_unf = 0; end
      m_pv = 0;
      if (p && o) begin
         if (q.size() == 0) begin q.push_back(d); m_unf = 1; end
         else begin m_pd = q[$]; q[$] = d; m_pv = 1; end
      end else if (p) begin
         if (q.size() == 7) m_ovf = 1;
         else q.push_back(d);
      end else if (o) begin
         if (q.size() == 0) m_unf = 1;
         else begin m_pd = q.pop_back(); m_pv = 1; end
      end
      if (q.size() > m_hwm) m_hwm = q.size();
   endtask

   initial begin
      a_rst_n = 0; a_push = 0; a_pop = 0; a_din = 0; a_clr = 0;
      b_rst_n = 0; b_push = 0; b_pop = 0; b_din = 0; b_clr = 0;

      tbl.push_back(mk(1,0,8'h11,0, 1,'h11,0,'h00,0,0,1));
      tbl.push_back(mk(1,0,8'h22,0, 2,'h22,0,'h00,0,0,2));
      tbl.push_back(mk(1,0,8'h33,0, 3,'h33,0,'h00,0,0,3));
      tbl.push_back(mk(0,1,8'h00,0, 2,'h22,1,'h33,0,0,3));
      tbl.push_back(mk(0,1,8'h00,0, 1,'h11,1,'h22,0,0,3));
      tbl.push_back(mk(0,1,8'h00,0, 0,'h00,1,'h11,0,0,3));
      tbl.push_back(mk(0,0,8'h00,0, 0,'h00,0,'h11,0,0,3));
      tbl.push_back(mk(1,0,8'ha1,0, 1,'ha1,0,'h11,0,0,3));
      tbl.push_back(mk(1,0,8'ha2,0, 2,'ha2,0,'h11,0,0,3));
      tbl.push_back(mk(1,0,8'ha3,0, 3,'ha3,0,'h11,0,0,3));
      tbl.push_back(mk(1,0,8'ha4,0, 4,'ha4,0,'h11,0,0,4));
      tbl.push_back(mk(1,0,8'ha5,0, 4,'ha4,0,'h11,1,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 3,'ha3,1,'ha4,1,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 2,'ha2,1,'ha3,1,0,4));
      tbl.push_back(mk(0,0,8'h00,1, 2,'ha2,0,'ha3,0,0,4));
      tbl.push_back(mk(1,1,8'h0c,0, 2,'h0c,1,'ha2,0,0,4));
      tbl.push_back(mk(1,0,8'h0d,0, 3,'h0d,0,'ha2,0,0,4));
      tbl.push_back(mk(1,0,8'h0e,0, 4,'h0e,0,'ha2,0,0,4));
      tbl.push_back(mk(1,1,8'h0f,0, 4,'h0f,1,'h0e,0,0,4));
      tbl.push_back(mk(1,0,8'h55,1, 4,'h0f,0,'h0e,1,0,4));
      tbl.push_back(mk(0,0,8'h00,1, 4,'h0f,0,'h0e,0,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 3,'h0d,1,'h0f,0,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 2,'h0c,1,'h0d,0,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 1,'ha1,1,'h0c,0,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 0,'h00,1,'ha1,0,0,4));
      tbl.push_back(mk(0,1,8'h00,0, 0,'h00,0,'ha1,0,1,4));
      tbl.push_back(mk(1,1,8'h05,0, 1,'h05,0,'ha1,0,1,4));
      tbl.push_back(mk(0,0,8'h00,1, 1,'h05,0,'ha1,0,0,4));

      repeat (3) @(posedge clk);
      #1;
      check_a("reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      a_rst_n = 1;

      for (int i = 0; i < tbl.size(); i++) begin
         step_a(tbl[i].p, tbl[i].o, tbl[i].d, tbl[i].c);
         check_a($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].pv,
                 tbl[i].pd, tbl[i].ovf, tbl[i].unf, tbl[i].hwm);
      end

      // async reset between edges with count=3 and a push in flight
      step_a(1, 0, 8'h66, 0);
      step_a(1, 0, 8'h67, 0);
      check_a("pre_arst", 3, 'h67, 0, 'ha1, 0, 0, 4);
      a_push = 1; a_din = 8'h68;
      #2 a_rst_n = 0;
      #1 check_a("arst", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      a_rst_n = 1; a_push = 1; a_din = 8'h77;
      @(posedge clk);
      #1 check_a("first_op", 1, 'h77, 0, 0, 0, 0, 1);
      a_push = 0;

      // random stream on instance B
      m_pd = 0; m_pv = 0; m_ovf = 0; m_unf = 0; m_hwm = 0;
      @(negedge clk);
      b_rst_n = 1;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         b_push = 1'($urandom_range(0, 1));
         b_pop  = 1'($urandom_range(0, 1));
         b_din  = 8'($urandom);
         b_clr  = ($urandom_range(0, 15) == 0);
         model_step(b_push, b_pop, b_din, b_clr);
         @(posedge clk);
         #1;
         chk("rnd count", 32'(b_cnt), q.size());
         chk("rnd top",   32'(b_top), (q.size() == 0) ? 0 : 32'(q[$]));
         chk("rnd pv",    32'(b_pv),  32'(m_pv));
         chk("rnd pd",    32'(b_pd),  32'(m_pd));
         chk("rnd ovf",   32'(b_ovf), 32'(m_ovf));
         chk("rnd unf",   32'(b_unf), 32'(m_unf));
         chk("rnd hwm",   32'(b_hwm), m_hwm);
         chk("rnd full",  32'(b_full),  32'(q.size() == 7));
         chk("rnd empty", 32'(b_empty), 32'(q.size() == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
